cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Shares one cache slave port among NUM_REQ requesters (e.g. instruction fetch, data load/store, snoop) using round-robin arbitration. It sits between the requester masters and the cache slave. It runs the cache's 4-phase request/valid handshake on both sides, and it latches command and data so that each transaction is atomic. Only one transaction is outstanding at a time.

## Interface
- NUM_REQ, 2: number of requesters, must be ≥2.
- DATAWIDTH, 8: data bus width.
- ADDRESSWIDTH, 32: address width.
- TIMEOUT_CYCLES, 255: watchdog limit. Used only with CACHE_ARB_TIMEOUT_EN.
- GW = $clog2(NUM_REQ). This is a localparam.

Ports:
- clock  in  1  Single clock; all logic is on the rising edge.
- reset  in  1  Synchronous, active-high.
- req_request  in  [NUM_REQ]  Per-requester 4-phase request.
- req_operation  in  [NUM_REQ] x inst_t  Per-requester operation.
- req_addr  in  [NUM_REQ][ADDRESSWIDTH]  Per-requester address.
- req_wdata  in  [NUM_REQ][DATAWIDTH]  Per-requester write data.
- req_valid  out  [NUM_REQ]  Per-requester completion. One-hot or zero.
- req_evict  out  [NUM_REQ]  Eviction flag. Meaningful only while the matching req_valid is high.
- req_rdata  out  DATAWIDTH  Read data, shared by all requesters. Qualified by req_valid.
- cache_operation  out  inst_t  Latched operation.
- cache_addr  out  ADDRESSWIDTH  Latched address.
- cache_wdata  out  DATAWIDTH  Latched write data.
- cache_request  out  1  Request to the cache.
- cache_valid  in  1  Cache completion.
- cache_evict  in  1  Cache eviction indication. Sampled with cache_valid.
- cache_rdata  in  DATAWIDTH  Cache read data. Sampled with cache_valid.
- grant_id  out  GW  Index of the current or last granted requester.
- busy  out  1  High in any state other than IDLE.
- timeout  out  1  One-cycle watchdog pulse.

## Operation
- The state machine has three states: IDLE, WAIT_CACHE and RESP.
- IDLE:
  - If any req_request bit is high, pick the first set bit at or after rr_ptr, searching upward with wrap.
  - At the next edge, latch that requester's operation, address and write data into cache_*, set grant_id, and go to WAIT_CACHE.
- WAIT_CACHE:
  - cache_request=1.
  - On cache_valid=1: latch cache_rdata into req_rdata and cache_evict into the evict register, then go to RESP.
- RESP:
  - cache_request=0, req_valid[grant_id]=1, req_evict[grant_id]=evict register.
  - Leave when cache_valid=0 and req_request[grant_id]=0 in the same cycle: go to IDLE and set rr_ptr=(grant_id+1) mod NUM_REQ.
- cache_* command outputs and req_rdata hold their values until the next grant or reset.
- Requests that are not granted wait; they are not dropped.
- A requester that drops req_request before its req_valid is not aborted. Its transaction completes, and it sees req_valid only if it re-raises req_request. The arbiter still waits for req_request=0 to leave RESP.
- rr_ptr wraps from NUM_REQ-1 to 0. NUM_REQ that is not a power of two must wrap correctly; rr_ptr never exceeds NUM_REQ-1.

## Timing
- Reset values:
  - Registered outputs: req_valid=0, req_evict=0, req_rdata=0, cache_operation=inst_t'(0), cache_addr=0, cache_wdata=0, cache_request=0, grant_id=0, busy=0, timeout=0.
  - Internal: rr_ptr=0, state=IDLE.
- Reset asserted mid-transaction forces the reset values at the next edge. The cache must tolerate cache_request dropping without the handshake completing.
- All outputs are registered.
- Latency from req_request rising (in IDLE) to cache_request=1 is 1 cycle.
- Latency from cache_valid=1 to req_valid=1 and cache_request=0 is 1 cycle.
- From RESP exit to the next cache_request there are at least 2 cycles: one cycle in IDLE, then the grant edge.
- Minimum transaction length is 4 cycles when the cache and the requester each respond in 0 cycles.

## Configuration
- CACHE_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_CACHE and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES with cache_valid still 0, pulse timeout=1 for one cycle and go to RESP with req_rdata=0 and evict=0.
  - cache_request drops on entry to RESP, as usual.
  - If cache_valid and the limit occur in the same cycle, cache_valid wins and timeout stays 0.
- CACHE_ARB_TIMEOUT_EN undefined: there is no counter and no abort path, timeout is tied to 0, and the arbiter waits indefinitely. The port list is identical in both builds.

## Structure
- cachepkg holds inst_t, which already exists, and a new arb_state_t enum {IDLE, WAIT_CACHE, RESP}.
- Sub-module cache_rr_pick is purely combinational.
  - Inputs: req mask and rr_ptr.
  - Outputs: any and index.
  - Reusable by other arbiters.

## Test plan
- Single requester: req_request[0]=1 at cycle 0, addr=0x100, cache_valid after 3 cycles with rdata=0xA5 → cache_request high cycles 1–4, cache_addr=0x100, req_valid[0]=1 with req_rdata=0xA5 at cycle 5. The block returns to IDLE after req_request[0] and cache_valid both drop.
- Simultaneous requests: NUM_REQ=3, all three held from reset → grants in order 0, 1, 2, 0, with grant_id and rr_ptr wrapping 2→0.
- Evict passthrough: cache_evict=1 together with cache_valid → req_evict[g]=1 for the whole RESP phase, and 0 for all other requesters.
- Slow release: requester holds req_request 5 cycles after req_valid → state stays RESP, no new grant, busy=1 throughout.
- Reset in WAIT_CACHE → at the next edge cache_request=0, busy=0, grant_id=0, and a fresh request afterwards is granted starting from requester 0.
- With CACHE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, cache never responds → timeout pulses once, 4 cycles after WAIT_CACHE entry, then req_valid=1 with req_rdata=0.

Source files
------------

// File: rtl/cachepkg.sv
// Shared types for the cache port arbiter and related cache-side blocks.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// inst_t      : cache operation code carried from a requester to the cache.
// arb_state_t : arbiter control states.
package cachepkg;

  typedef enum logic [1:0] {
    INST_NOP   = 2'd0,
    INST_READ  = 2'd1,
    INST_WRITE = 2'd2,
    INST_FLUSH = 2'd3
  } inst_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CACHE = 2'd1,
    RESP       = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_rr_pick.sv
// Round-robin picker: first set bit of req at or above rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req    : request mask, one bit per requester.
//   rr_ptr : search start index, must be below NUM_REQ.
//   any    : at least one request bit is set.
//   index  : chosen requester; 0 when any is low.
module cache_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int GW = $clog2(NUM_REQ);

  always_comb begin
    int cand;
    any   = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap by subtraction so non-power-of-two counts never reach NUM_REQ.
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any && req[GW'(cand)]) begin
        any   = 1'b1;
        index = GW'(cand);
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache slave port among NUM_REQ requesters.
// Latency: 1 cycle request->cache_request, 1 cycle cache_valid->req_valid; min 4-cycle transaction.
// Backpressure: one transaction in flight; losers keep req_request high and wait, nothing is dropped.
//
// Ports:
//   clock, reset          : single rising-edge clock, synchronous active-high reset.
//   req_request/operation/addr/wdata : per-requester 4-phase request and command.
//   req_valid, req_evict  : per-requester completion (one-hot or zero) and eviction flag.
//   req_rdata             : shared read data, qualified by req_valid.
//   cache_operation/addr/wdata, cache_request : latched command and request to the cache.
//   cache_valid, cache_evict, cache_rdata     : cache completion, sampled together.
//   grant_id, busy, timeout                   : current/last grant, non-IDLE flag, watchdog pulse.
//
// Build option: define CACHE_ARB_TIMEOUT_EN to add a watchdog that aborts a
// cache wait after TIMEOUT_CYCLES cycles. Without it timeout is constant 0.
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATAWIDTH      = 8,
  parameter int ADDRESSWIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_request,
  input  inst_t [NUM_REQ-1:0]                    req_operation,
  input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_evict,
  output logic [DATAWIDTH-1:0]                   req_rdata,
  output inst_t                                  cache_operation,
  output logic [ADDRESSWIDTH-1:0]                cache_addr,
  output logic [DATAWIDTH-1:0]                   cache_wdata,
  output logic                                   cache_request,
  input  logic                                   cache_valid,
  input  logic                                   cache_evict,
  input  logic [DATAWIDTH-1:0]                   cache_rdata,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id,
  output logic                                   busy,
  output logic                                   timeout
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cache_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t        state, state_nxt;
  logic [GW-1:0]     rr_ptr;
  logic              pick_any;
  logic [GW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] grant_oh;

  // Single-cycle events produced by the next-state logic and consumed by the datapath.
  logic grant_evt;    // IDLE -> WAIT_CACHE
  logic done_evt;     // WAIT_CACHE -> RESP on cache_valid
  logic abort_evt;    // WAIT_CACHE -> RESP on watchdog expiry
  logic release_evt;  // RESP -> IDLE
  logic tmo_hit;

  cache_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_request),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .index  (pick_idx)
  );

  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_evt   = 1'b0;
    done_evt    = 1'b0;
    abort_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = WAIT_CACHE;
          grant_evt = 1'b1;
        end
      end
      WAIT_CACHE: begin
        // A cache response in the same cycle as watchdog expiry takes priority.
        if (cache_valid) begin
          state_nxt = RESP;
          done_evt  = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          abort_evt = 1'b1;
        end
      end
      RESP: begin
        // Both sides must have returned to zero before the port is reused.
        if (!cache_valid && !req_request[grant_id]) begin
          state_nxt   = IDLE;
          release_evt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr          <= '0;
      grant_id        <= '0;
      cache_operation <= inst_t'(0);
      cache_addr      <= '0;
      cache_wdata     <= '0;
      cache_request   <= 1'b0;
      req_valid       <= '0;
      req_evict       <= '0;
      req_rdata       <= '0;
      busy            <= 1'b0;
    end else begin
      if (grant_evt) begin
        cache_operation <= req_operation[pick_idx];
        cache_addr      <= req_addr[pick_idx];
        cache_wdata     <= req_wdata[pick_idx];
        grant_id        <= pick_idx;
        cache_request   <= 1'b1;
        busy            <= 1'b1;
      end
      if (done_evt) begin
        cache_request <= 1'b0;
        req_rdata     <= cache_rdata;
        req_valid     <= grant_oh;
        req_evict     <= cache_evict ? grant_oh : '0;
      end
      if (abort_evt) begin
        cache_request <= 1'b0;
        req_rdata     <= '0;
        req_valid     <= grant_oh;
        req_evict     <= '0;
      end
      if (release_evt) begin
        req_valid <= '0;
        req_evict <= '0;
        busy      <= 1'b0;
        rr_ptr    <= (grant_id == GW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Counts completed WAIT_CACHE cycles; saturates so it cannot wrap and re-fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= abort_evt;
      if (grant_evt) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_CACHE && tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign tmo_hit = (state == WAIT_CACHE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter with three requesters.
// Directed per-cycle vector table, hand-written corner sequences, then randomized traffic.
// Cache and requesters are modelled as bench agents honouring the 4-phase handshake.
module tb_cache_port_arbiter;
  import cachepkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [2:0]            req_request;
  inst_t [2:0]           req_operation;
  logic [2:0][31:0]      req_addr;
  logic [2:0][7:0]       req_wdata;
  logic [2:0]            req_valid;
  logic [2:0]            req_evict;
  logic [7:0]            req_rdata;
  inst_t                 cache_operation;
  logic [31:0]           cache_addr;
  logic [7:0]            cache_wdata;
  logic                  cache_request;
  logic                  cache_valid;
  logic                  cache_evict;
  logic [7:0]            cache_rdata;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  timeout;

  int checks = 0;
  int failures = 0;

  cache_port_arbiter #(
    .NUM_REQ        (3),
    .DATAWIDTH      (8),
    .ADDRESSWIDTH   (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_request     (req_request),
    .req_operation   (req_operation),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_valid       (req_valid),
    .req_evict       (req_evict),
    .req_rdata       (req_rdata),
    .cache_operation (cache_operation),
    .cache_addr      (cache_addr),
    .cache_wdata     (cache_wdata),
    .cache_request   (cache_request),
    .cache_valid     (cache_valid),
    .cache_evict     (cache_evict),
    .cache_rdata     (cache_rdata),
    .grant_id        (grant_id),
    .busy            (busy),
    .timeout         (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Spec rule: first requester at or after ptr, searching upward with wrap.
  function automatic int rr_first(input logic [2:0] m, input int p);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (p + k) % 3;
      if (((m >> j) & 3'b001) != 3'b000) return j;
    end
    return -1;
  endfunction

  task automatic wait_creq(input string nm);
    for (int k = 0; k < 20 && cache_request !== 1'b1; k++) tick();
    chk(nm, cache_request, 1'b1);
  endtask

  task automatic run_txn(input logic [1:0] r, input logic [7:0] rd);
    req_request[r] = 1'b1;
    wait_creq("txn_creq");
    chk("txn_gid", grant_id, r);
    cache_valid = 1'b1;
    cache_rdata = rd;
    tick();
    chk("txn_valid", req_valid, 3'b001 << r);
    chk("txn_rdata", req_rdata, rd);
    req_request[r] = 1'b0;
    cache_valid = 1'b0;
    tick();
    chk("txn_idle", busy, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic        cv;
    logic        ev;
    logic [7:0]  rd;
    logic        creq;
    logic [2:0]  rv;
    logic [2:0]  rev;
    logic        bsy;
    logic [7:0]  rdat;
    logic [1:0]  gid;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[20];
  logic [1:0] exp_order[4];
  logic [7:0] wd_tab[3];

  // Random-phase state
  int         st[3];
  int         cnt[3];
  int         cdly;
  int         m_phase;
  int         m_ptr;
  int         ncomp;
  int         g;
  logic [1:0] m_g;
  logic [7:0] m_rd;
  logic       m_ev;

  initial begin
    // Rows: inputs for one cycle, then outputs expected after the following edge.
    tbl[0]  = '{3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b000, 1'b1, 8'h00, 2'd0, 32'h100};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[0];
    tbl[4]  = '{3'b001, 1'b1, 1'b0, 8'hA5, 1'b0, 3'b001, 3'b000, 1'b1, 8'hA5, 2'd0, 32'h100};
    tbl[5]  = tbl[4];
    tbl[6]  = '{3'b000, 1'b1, 1'b0, 8'hA5, 1'b0, 3'b001, 3'b000, 1'b1, 8'hA5, 2'd0, 32'h100};
    tbl[7]  = '{3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'hA5, 2'd0, 32'h100};
    tbl[8]  = tbl[7];
    tbl[9]  = '{3'b100, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b000, 1'b1, 8'hA5, 2'd2, 32'h2C0};
    tbl[10] = '{3'b100, 1'b1, 1'b1, 8'h3C, 1'b0, 3'b100, 3'b100, 1'b1, 8'h3C, 2'd2, 32'h2C0};
    tbl[11] = '{3'b100, 1'b0, 1'b0, 8'h00, 1'b0, 3'b100, 3'b100, 1'b1, 8'h3C, 2'd2, 32'h2C0};
    tbl[12] = '{3'b101, 1'b0, 1'b0, 8'h00, 1'b0, 3'b100, 3'b100, 1'b1, 8'h3C, 2'd2, 32'h2C0};
    tbl[13] = tbl[12];
    tbl[14] = tbl[12];
    tbl[15] = tbl[12];
    tbl[16] = '{3'b001, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'h3C, 2'd2, 32'h2C0};
    tbl[17] = '{3'b001, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b000, 1'b1, 8'h3C, 2'd0, 32'h100};
    tbl[18] = '{3'b001, 1'b1, 1'b0, 8'h11, 1'b0, 3'b001, 3'b000, 1'b1, 8'h11, 2'd0, 32'h100};
    tbl[19] = '{3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'h11, 2'd0, 32'h100};
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2; exp_order[3] = 2'd0;
    wd_tab[0] = 8'h10; wd_tab[1] = 8'h21; wd_tab[2] = 8'h32;

    reset         = 1'b1;
    req_request   = '0;
    req_operation[0] = INST_READ;
    req_operation[1] = INST_WRITE;
    req_operation[2] = INST_FLUSH;
    req_addr[0]   = 32'h100;
    req_addr[1]   = 32'h1A0;
    req_addr[2]   = 32'h2C0;
    req_wdata[0]  = wd_tab[0];
    req_wdata[1]  = wd_tab[1];
    req_wdata[2]  = wd_tab[2];
    cache_valid   = 1'b0;
    cache_evict   = 1'b0;
    cache_rdata   = '0;
    tick();
    tick();

    // Reset values
    chk("rst_req_valid", req_valid, 3'b000);
    chk("rst_req_evict", req_evict, 3'b000);
    chk("rst_req_rdata", req_rdata, 8'h00);
    chk("rst_cache_op", cache_operation, INST_NOP);
    chk("rst_cache_addr", cache_addr, 32'h0);
    chk("rst_cache_wdata", cache_wdata, 8'h00);
    chk("rst_cache_request", cache_request, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_no_req_busy", busy, 1'b0);

    // Directed vector table: single requester, evict, slow release, wrap.
    for (int i = 0; i < 20; i++) begin
      req_request = tbl[i].req;
      cache_valid = tbl[i].cv;
      cache_evict = tbl[i].ev;
      cache_rdata = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d_creq", i), cache_request, tbl[i].creq);
      chk($sformatf("vec%0d_valid", i), req_valid, tbl[i].rv);
      chk($sformatf("vec%0d_evict", i), req_evict, tbl[i].rev);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_rdata", i), req_rdata, tbl[i].rdat);
      chk($sformatf("vec%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("vec%0d_addr", i), cache_addr, tbl[i].addr);
      chk($sformatf("vec%0d_wdata", i), cache_wdata, wd_tab[tbl[i].gid]);
      chk($sformatf("vec%0d_timeout", i), timeout, 1'b0);
    end

    // All three requesters held from reset: grants 0,1,2,0.
    reset = 1'b1;
    req_request = 3'b111;
    cache_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wait_creq("rr_creq");
      chk("rr_gid", grant_id, exp_order[n]);
      chk("rr_addr", cache_addr, req_addr[exp_order[n]]);
      chk("rr_op", cache_operation, req_operation[exp_order[n]]);
      cache_valid = 1'b1;
      cache_rdata = 8'h40 + 8'(n);
      tick();
      chk("rr_valid", req_valid, 3'b001 << exp_order[n]);
      chk("rr_rdata", req_rdata, 8'h40 + 8'(n));
      req_request[exp_order[n]] = 1'b0;
      cache_valid = 1'b0;
      tick();
      chk("rr_release", busy, 1'b0);
      req_request[exp_order[n]] = 1'b1;
    end
    req_request = 3'b000;
    tick();

    // Reset during WAIT_CACHE with rr_ptr parked at 2.
    run_txn(2'd1, 8'h77);
    req_request = 3'b001;
    tick();
    chk("rstw_gid", grant_id, 2'd0);
    chk("rstw_creq", cache_request, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("rstw_creq_low", cache_request, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_gid0", grant_id, 2'd0);
    chk("rstw_addr", cache_addr, 32'h0);
    reset = 1'b0;
    req_request = 3'b111;
    tick();
    chk("rstw_fresh_gid", grant_id, 2'd0);
    chk("rstw_fresh_creq", cache_request, 1'b1);
    cache_valid = 1'b1;
    cache_rdata = 8'h5A;
    tick();
    chk("rstw_fresh_rdata", req_rdata, 8'h5A);
    req_request = 3'b000;
    cache_valid = 1'b0;
    tick();
    chk("rstw_fresh_idle", busy, 1'b0);

    // Cache never answers.
    req_request = 3'b010;
    tick();
    chk("tmo_entry_creq", cache_request, 1'b1);
    chk("tmo_entry_gid", grant_id, 2'd1);
`ifdef CACHE_ARB_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("tmo_early", timeout, 1'b0);
      chk("tmo_wait_creq", cache_request, 1'b1);
    end
    tick();
    chk("tmo_pulse", timeout, 1'b1);
    chk("tmo_valid", req_valid, 3'b010);
    chk("tmo_rdata", req_rdata, 8'h00);
    chk("tmo_evict", req_evict, 3'b000);
    chk("tmo_creq_low", cache_request, 1'b0);
    req_request = 3'b000;
    tick();
    chk("tmo_once", timeout, 1'b0);
    chk("tmo_idle", busy, 1'b0);
`else
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("notmo_timeout", timeout, 1'b0);
      chk("notmo_creq", cache_request, 1'b1);
      chk("notmo_busy", busy, 1'b1);
    end
    cache_valid = 1'b1;
    cache_rdata = 8'h66;
    tick();
    chk("notmo_valid", req_valid, 3'b010);
    chk("notmo_rdata", req_rdata, 8'h66);
    req_request = 3'b000;
    cache_valid = 1'b0;
    tick();
    chk("notmo_idle", busy, 1'b0);
`endif

    // Randomized traffic against a transaction-level model.
    reset = 1'b1;
    req_request = 3'b000;
    cache_valid = 1'b0;
    tick();
    reset = 1'b0;
    m_phase = 0;
    m_ptr = 0;
    m_g = 2'd0;
    m_rd = 8'h00;
    m_ev = 1'b0;
    ncomp = 0;
    cdly = $urandom_range(0, 2);
    for (int i = 0; i < 3; i++) begin
      st[i] = 0;
      cnt[i] = $urandom_range(0, 3);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      // Judge the edge just taken using the inputs that were applied to it.
      case (m_phase)
        0: begin
          if (req_request != 3'b000) begin
            g = rr_first(req_request, m_ptr);
            m_g = g[1:0];
            chk("rnd_grant_creq", cache_request, 1'b1);
            chk("rnd_grant_gid", grant_id, m_g);
            chk("rnd_grant_addr", cache_addr, req_addr[m_g]);
            chk("rnd_grant_wdata", cache_wdata, req_wdata[m_g]);
            chk("rnd_grant_op", cache_operation, req_operation[m_g]);
            m_phase = 1;
          end else begin
            chk("rnd_idle_busy", busy, 1'b0);
          end
        end
        1: begin
          if (cache_valid) begin
            m_rd = cache_rdata;
            m_ev = cache_evict;
            chk("rnd_done_creq", cache_request, 1'b0);
            chk("rnd_done_valid", req_valid, 3'b001 << m_g);
            chk("rnd_done_rdata", req_rdata, m_rd);
            chk("rnd_done_evict", req_evict, m_ev ? (3'b001 << m_g) : 3'b000);
            m_phase = 2;
          end else begin
            chk("rnd_wait_creq", cache_request, 1'b1);
            chk("rnd_wait_valid", req_valid, 3'b000);
          end
        end
        default: begin
          if (!cache_valid && !req_request[m_g]) begin
            chk("rnd_rel_busy", busy, 1'b0);
            chk("rnd_rel_valid", req_valid, 3'b000);
            m_ptr = (int'(m_g) + 1) % 3;
            m_phase = 0;
            ncomp++;
          end else begin
            chk("rnd_resp_busy", busy, 1'b1);
            chk("rnd_resp_valid", req_valid, 3'b001 << m_g);
            chk("rnd_resp_rdata", req_rdata, m_rd);
            chk("rnd_resp_evict", req_evict, m_ev ? (3'b001 << m_g) : 3'b000);
          end
        end
      endcase
      chk("rnd_timeout", timeout, 1'b0);

      // Cache agent: respond after a short delay, hold valid until request drops.
      if (cache_valid) begin
        if (!cache_request) begin
          cache_valid = 1'b0;
          cdly = $urandom_range(0, 2);
        end
      end else if (cache_request) begin
        if (cdly == 0) begin
          cache_valid = 1'b1;
          cache_rdata = 8'($urandom);
          cache_evict = 1'($urandom);
        end else begin
          cdly--;
        end
      end

      // Requester agents.
      for (int i = 0; i < 3; i++) begin
        case (st[i])
          0: begin
            if (cnt[i] == 0) begin
              req_request[i]   = 1'b1;
              req_addr[i]      = $urandom;
              req_wdata[i]     = 8'($urandom);
              req_operation[i] = inst_t'(2'($urandom_range(0, 3)));
              st[i] = 1;
            end else begin
              cnt[i]--;
            end
          end
          1: begin
            if (req_valid[i]) begin
              st[i] = 2;
              cnt[i] = $urandom_range(0, 3);
            end else if ($urandom_range(0, 31) == 0) begin
              req_request[i] = 1'b0;
              st[i] = 0;
              cnt[i] = $urandom_range(0, 4);
            end
          end
          default: begin
            if (cnt[i] == 0) begin
              req_request[i] = 1'b0;
              st[i] = 0;
              cnt[i] = $urandom_range(0, 4);
            end else begin
              cnt[i]--;
            end
          end
        endcase
      end
    end
    chk("rnd_progress", ncomp > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
